// File: rtl/cmd_fetch_if.sv
// Bus bundle for cmd_fetch: SDRAM burst command port, SDRAM read-data port
// and the FWFT command stream toward the scheduler.
// master = the prefetcher, slave = memory controller plus consumer.
interface cmd_fetch_if;
   // SDRAM burst command port
   logic        mem_cmd_en;
   logic [2:0]  mem_cmd_instr;
   logic [5:0]  mem_cmd_bl;
   logic [29:0] mem_cmd_byte_addr;
   logic        mem_cmd_full;
   // SDRAM read-data port
   logic        mem_rd_en;
   logic [31:0] mem_rd_data;
   logic        mem_rd_empty;
   // command stream toward the scheduler
   logic        valid;
   logic        rd_en;
   logic [31:0] cmd;

   modport master (
      output mem_cmd_en, mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr,
      output mem_rd_en, valid, cmd,
      input  mem_cmd_full, mem_rd_data, mem_rd_empty, rd_en
   );

   modport slave (
      input  mem_cmd_en, mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr,
      input  mem_rd_en, valid, cmd,
      output mem_cmd_full, mem_rd_data, mem_rd_empty, rd_en
   );
endinterface

// File: rtl/cmd_fetch.sv
// cmd_fetch: command prefetcher for the scheduler FIFO port.
// On start, reads cmd_size commands of BURST_LEN words each from SDRAM,
// one burst per command, into an internal FWFT buffer. A burst is only
// requested when the buffer has room for the whole command, so the buffer
// can never overflow.
// Optional feature macro: CMD_OPCHECK_EN -- checks the op_type field of
// word 0 of every command, raises sticky op_err and stops fetching after
// the current burst on an illegal value.
module cmd_fetch #(
   parameter int unsigned BURST_LEN     = 8,
   parameter int unsigned FIFO_DEPTH    = 16,
   parameter logic [29:0] CMD_BASE_ADDR = 30'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [6:0]  cmd_size,
   output logic        busy,
   output logic        done,
`ifdef CMD_OPCHECK_EN
   output logic        op_err,
`endif
   cmd_fetch_if.master bus
);

   localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

   localparam logic [29:0]       BURST_BYTES = 30'(4 * BURST_LEN);
   localparam logic [CNT_W-1:0]  BURST_WORDS = CNT_W'(BURST_LEN);
   localparam logic [CNT_W-1:0]  DEPTH_WORDS = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
   localparam logic [PTR_W-1:0]  PTR_ONE     = PTR_W'(1);
   localparam logic [BEAT_W-1:0] BEAT_ONE    = BEAT_W'(1);
   localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BURST_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ROOM,
      S_ISSUE,
      S_COLLECT,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [31:0]       buf_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic [BEAT_W-1:0] beat_q;
   logic [6:0]        fetched_q;
   logic [6:0]        size_q;
   logic [29:0]       addr_q;

   logic valid_w;
   logic push;
   logic pop;
   logic flush;
   logic last_beat;
   logic has_room;
   logic stop;

   // A start is accepted only while not fetching; it also restarts the buffer.
   assign flush     = start && (state_q == S_IDLE || state_q == S_DONE);
   assign push      = bus.mem_rd_en;
   assign valid_w   = (count_q != '0);
   assign pop       = bus.rd_en && valid_w;
   assign last_beat = (beat_q == LAST_BEAT);
   assign has_room  = (DEPTH_WORDS - count_q) >= BURST_WORDS;

`ifdef CMD_OPCHECK_EN
   logic op_bad;
   logic op_err_q;

   // Word 0 of each command carries op_type in bits [2:0]; flag illegal codes.
   always_comb begin
      op_bad = push && (beat_q == '0) &&
               !(bus.mem_rd_data[2:0] inside {3'b000, 3'b001, 3'b100, 3'b101});
   end

   // Sticky error flag, cleared only by an accepted start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         op_err_q <= 1'b0;
      else if (flush)  op_err_q <= 1'b0;
      else if (op_bad) op_err_q <= 1'b1;
   end

   assign stop   = op_err_q || op_bad;
   assign op_err = op_err_q;
`else
   assign stop = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block evaluation order.
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic for the fetch sequence.
   always_comb begin
      // NOTE: default assigned first so no path leaves state_d unassigned
      // (which would infer a latch).
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) state_d = (cmd_size == '0) ? S_DONE : S_ROOM;
         end
         S_ROOM: begin
            if (has_room && !bus.mem_cmd_full) state_d = S_ISSUE;
         end
         S_ISSUE: begin
            state_d = S_COLLECT;
         end
         S_COLLECT: begin
            if (push && last_beat) begin
               state_d = ((fetched_q + 7'd1) == size_q || stop) ? S_DONE : S_ROOM;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Burst address, beat and command counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q    <= CMD_BASE_ADDR;
         fetched_q <= '0;
         size_q    <= '0;
         beat_q    <= '0;
      end else if (flush) begin
         addr_q    <= CMD_BASE_ADDR;
         fetched_q <= '0;
         size_q    <= cmd_size;
         beat_q    <= '0;
      end else if (push) begin
         if (last_beat) begin
            beat_q    <= '0;
            fetched_q <= fetched_q + 7'd1;
            addr_q    <= addr_q + BURST_BYTES;
         end else begin
            beat_q <= beat_q + BEAT_ONE;
         end
      end
   end

   // Buffer pointers and occupancy; a start discards anything left over.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

   // Buffer storage write.
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; occupancy and pointers alone decide what
      // is valid, which keeps the array a plain RAM.
      if (push) buf_mem[wr_ptr_q] <= bus.mem_rd_data;
   end

   // Overflow is excluded by the room check before each burst.
   always_ff @(posedge clk) begin
      if (!rst && push && !pop) assert (count_q != DEPTH_WORDS);
   end

   assign busy                  = (state_q == S_ROOM) || (state_q == S_ISSUE) ||
                                  (state_q == S_COLLECT);
   assign done                  = (state_q == S_DONE);
   assign bus.mem_cmd_en        = (state_q == S_ISSUE);
   assign bus.mem_cmd_instr     = 3'b001;
   assign bus.mem_cmd_bl        = 6'(BURST_LEN - 1);
   assign bus.mem_cmd_byte_addr = addr_q;
   assign bus.mem_rd_en         = (state_q == S_COLLECT) && !bus.mem_rd_empty;
   assign bus.valid             = valid_w;
   assign bus.cmd               = valid_w ? buf_mem[rd_ptr_q] : '0;

endmodule
